// File: rtl/dll_pkg.sv
// ---------------------------------------------------------------------------
// dll_pkg
// Shared definitions for the data link layer transmit retry path.
//   DLC_DL_ACTIVE   : DLCMSM encoding of the DL_ACTIVE state
//   SEQ_W/TLP_W/DLL_TLP_W : sequence, TLP body and sequenced-TLP widths
//   *_MSB / *_LSB   : field positions inside a sequenced TLP
//                     (seq | TLP | LCRC)
//   retry_state_e   : retry buffer FSM states
//   seq_dist()      : modulo-4096 distance between two sequence numbers
// ---------------------------------------------------------------------------
package dll_pkg;

    localparam logic [1:0] DLC_DL_ACTIVE = 2'b11;

    localparam int SEQ_W     = 12;
    localparam int TLP_W     = 1152;
    localparam int DLL_TLP_W = 1196;

    localparam int SEQ_MSB  = 1195;
    localparam int SEQ_LSB  = 1184;
    localparam int TLP_MSB  = 1183;
    localparam int TLP_LSB  = 32;
    localparam int LCRC_MSB = 31;
    localparam int LCRC_LSB = 0;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_REPLAY = 1'b1
    } retry_state_e;

    // Sequence numbers live on a 12-bit ring, so plain subtraction
    // truncated to SEQ_W gives the forward distance from b to a.
    function automatic logic [SEQ_W-1:0] seq_dist(input logic [SEQ_W-1:0] a,
                                                  input logic [SEQ_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/dll_retry_ram.sv
// ---------------------------------------------------------------------------
// dll_retry_ram
// Simple dual-port storage for the retry buffer: one write port and one
// registered read port. The read register doubles as the retry buffer's
// output data register, so it only updates when re_i is high.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i          : read enable / address
//   rdata_o                : registered read data
// ---------------------------------------------------------------------------
module dll_retry_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 1196
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-through on an address collision lets an entry written this
    // cycle be loaded into the output in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dll_tx_retry_buffer.sv
// ---------------------------------------------------------------------------
// dll_tx_retry_buffer
// Holds sequenced TLPs until they are acknowledged, forwards them to the PHY
// TX over valid/ready, and replays all unacknowledged TLPs (oldest first) on
// a NAK or on a replay-timer timeout.
//   clk, rst_n        : clock, async active-low reset
//   dlc_state_i       : DLCMSM state; anything but DL_ACTIVE flushes
//   dll_tlp_i/_valid_i: sequenced TLP write from the TLP generator
//   full_o            : buffer full, upstream must hold off
//   ack_valid_i, nak_valid_i, ackd_seq_i : received ACK/NAK DLLP
//   tlp_o, tlp_valid_o, tlp_ready_i      : TLP stream to PHY TX
//   replaying_o       : high while replaying
//   retrain_req_o     : pulse when REPLAY_NUM rolls over
//   overflow_o        : pulse when a write was dropped because full
// ---------------------------------------------------------------------------
module dll_tx_retry_buffer
    import dll_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           dlc_state_i,
    input  logic [DLL_TLP_W-1:0] dll_tlp_i,
    input  logic                 dll_tlp_valid_i,
    output logic                 full_o,
    input  logic                 ack_valid_i,
    input  logic                 nak_valid_i,
    input  logic [SEQ_W-1:0]     ackd_seq_i,
    output logic [DLL_TLP_W-1:0] tlp_o,
    output logic                 tlp_valid_o,
    input  logic                 tlp_ready_i,
    output logic                 replaying_o,
    output logic                 retrain_req_o,
    output logic                 overflow_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int TW = $clog2(REPLAY_TIMEOUT);

    retry_state_e   state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  ack_ptr_q, ack_ptr_d;
    logic [1:0]     replay_num_q, replay_num_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           full_q, full_d;
    logic           tlp_valid_q, tlp_valid_d;
    logic           overflow_q, overflow_d;
    logic           retrain_q, retrain_d;
    logic [SEQ_W-1:0] seq_q [DEPTH];

    logic             active;
    logic             wr_en;
    logic             load;
    logic             purge;
    logic             timeout;
    logic             trigger;
    logic [PW-1:0]    sent_cnt;
    logic [SEQ_W-1:0] ack_dist;
    logic [1:0]       num_base;

    always_comb begin
        active   = (dlc_state_i == DLC_DL_ACTIVE);
        wr_en    = active && dll_tlp_valid_i && !full_q;
        sent_cnt = rd_ptr_q - ack_ptr_q;
        ack_dist = seq_dist(ackd_seq_i, seq_q[ack_ptr_q[IW-1:0]]);
        // Only an ACK/NAK that lands inside the sent window purges; anything
        // else is stale or a duplicate.
        purge    = active && (ack_valid_i || nak_valid_i)
                   && (ack_dist < SEQ_W'(sent_cnt));
        timeout  = (state_q == ST_NORMAL) && (rd_ptr_q != ack_ptr_q)
                   && (timer_q == TW'(REPLAY_TIMEOUT - 1));
        // A NAK and a timeout in the same cycle collapse into one trigger.
        trigger  = active && (nak_valid_i || timeout);
        // No load on a trigger cycle: rd_ptr is being rewound, and a held
        // TLP must finish its handshake before replayed entries follow.
        load     = active && !trigger && (!tlp_valid_q || tlp_ready_i)
                   && ((rd_ptr_q != wr_ptr_q) || wr_en);

        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        ack_ptr_d    = '0;
        state_d      = ST_NORMAL;
        replay_num_d = '0;
        num_base     = '0;
        timer_d      = '0;
        retrain_d    = 1'b0;
        tlp_valid_d  = 1'b0;
        overflow_d   = 1'b0;
        full_d       = 1'b0;

        if (active) begin
            wr_ptr_d  = wr_ptr_q + PW'(wr_en);
            ack_ptr_d = purge ? (ack_ptr_q + PW'(ack_dist) + PW'(1)) : ack_ptr_q;

            if (trigger) begin
                rd_ptr_d = ack_ptr_d;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(load);
            end

            state_d = state_q;
            if (trigger) begin
                state_d = ST_REPLAY;
            end else if ((state_q == ST_REPLAY) && (rd_ptr_q == wr_ptr_q)) begin
                state_d = ST_NORMAL;
            end

            // Forward progress clears the replay count before a same-cycle
            // NAK bumps it again.
            num_base     = purge ? 2'd0 : replay_num_q;
            replay_num_d = trigger ? (num_base + 2'd1) : num_base;
            retrain_d    = trigger && (num_base == 2'd3);

            if (!purge && !trigger && (state_q == ST_NORMAL)
                && (rd_ptr_q != ack_ptr_q)) begin
                timer_d = timer_q + TW'(1);
            end

            if (load) begin
                tlp_valid_d = 1'b1;
            end else begin
                tlp_valid_d = tlp_valid_q && !tlp_ready_i;
            end

            overflow_d = dll_tlp_valid_i && full_q;
            full_d     = ((wr_ptr_d - ack_ptr_d) == PW'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ack_ptr_q    <= '0;
            replay_num_q <= '0;
            timer_q      <= '0;
            full_q       <= 1'b0;
            tlp_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            retrain_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ack_ptr_q    <= ack_ptr_d;
            replay_num_q <= replay_num_d;
            timer_q      <= timer_d;
            full_q       <= full_d;
            tlp_valid_q  <= tlp_valid_d;
            overflow_q   <= overflow_d;
            retrain_q    <= retrain_d;
        end
    end

    // Sequence numbers are kept in flops so the purge distance can be
    // computed combinationally from the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                seq_q[i] <= '0;
            end
        end else if (wr_en) begin
            seq_q[wr_ptr_q[IW-1:0]] <= dll_tlp_i[SEQ_MSB:SEQ_LSB];
        end
    end

    dll_retry_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DLL_TLP_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[IW-1:0]),
        .wdata_i (dll_tlp_i),
        .re_i    (load),
        .raddr_i (rd_ptr_q[IW-1:0]),
        .rdata_o (tlp_o)
    );

    assign full_o        = full_q;
    assign tlp_valid_o   = tlp_valid_q;
    assign replaying_o   = (state_q == ST_REPLAY);
    assign retrain_req_o = retrain_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_dll_tx_retry_buffer.sv
// ---------------------------------------------------------------------------
// tb_dll_tx_retry_buffer
// Directed self-checking bench for dll_tx_retry_buffer.
// ---------------------------------------------------------------------------
module tb_dll_tx_retry_buffer;
    import dll_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           dlc_state_i;
    logic [DLL_TLP_W-1:0] dll_tlp_i;
    logic                 dll_tlp_valid_i;
    logic                 full_o;
    logic                 ack_valid_i;
    logic                 nak_valid_i;
    logic [SEQ_W-1:0]     ackd_seq_i;
    logic [DLL_TLP_W-1:0] tlp_o;
    logic                 tlp_valid_o;
    logic                 tlp_ready_i;
    logic                 replaying_o;
    logic                 retrain_req_o;
    logic                 overflow_o;

    int assertions = 0;
    int failures   = 0;

    logic [SEQ_W-1:0] got_seq [16];
    logic             got_ok  [16];
    int               got_n;

    dll_tx_retry_buffer #(
        .DEPTH          (16),
        .REPLAY_TIMEOUT (1024)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dlc_state_i     (dlc_state_i),
        .dll_tlp_i       (dll_tlp_i),
        .dll_tlp_valid_i (dll_tlp_valid_i),
        .full_o          (full_o),
        .ack_valid_i     (ack_valid_i),
        .nak_valid_i     (nak_valid_i),
        .ackd_seq_i      (ackd_seq_i),
        .tlp_o           (tlp_o),
        .tlp_valid_o     (tlp_valid_o),
        .tlp_ready_i     (tlp_ready_i),
        .replaying_o     (replaying_o),
        .retrain_req_o   (retrain_req_o),
        .overflow_o      (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a recognisable sequenced TLP for a given sequence number.
    function automatic logic [DLL_TLP_W-1:0] mk(input int s);
        logic [DLL_TLP_W-1:0] t;
        t = '0;
        t[SEQ_MSB:SEQ_LSB] = 12'(s);
        for (int i = 0; i < TLP_W / 32; i++) begin
            t[TLP_LSB + 32*i +: 32] = {20'hC0DE0, 12'(s)} + 32'(i);
        end
        t[LCRC_MSB:LCRC_LSB] = ~{20'h0, 12'(s)};
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_tlp(input int s);
        dll_tlp_i       = mk(s);
        dll_tlp_valid_i = 1'b1;
        step();
        dll_tlp_valid_i = 1'b0;
    endtask

    task automatic send_acknak(input logic is_nak, input int s);
        ackd_seq_i  = 12'(s);
        ack_valid_i = !is_nak;
        nak_valid_i = is_nak;
        step();
        ack_valid_i = 1'b0;
        nak_valid_i = 1'b0;
    endtask

    task automatic flush();
        dlc_state_i = 2'b00;
        step();
        dlc_state_i = DLC_DL_ACTIVE;
    endtask

    // Record every handshake seen over a fixed window of cycles.
    task automatic collect(input int cycles);
        got_n = 0;
        for (int c = 0; c < cycles; c++) begin
            if (tlp_valid_o && tlp_ready_i && got_n < 16) begin
                got_seq[got_n] = tlp_o[SEQ_MSB:SEQ_LSB];
                got_ok[got_n]  = (tlp_o === mk(int'(tlp_o[SEQ_MSB:SEQ_LSB])));
                got_n++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        dlc_state_i     = DLC_DL_ACTIVE;
        dll_tlp_i       = '0;
        dll_tlp_valid_i = 1'b0;
        ack_valid_i     = 1'b0;
        nak_valid_i     = 1'b0;
        ackd_seq_i      = '0;
        tlp_ready_i     = 1'b1;
        #12;
        assertions++;
        if ({tlp_valid_o, full_o, replaying_o, retrain_req_o, overflow_o} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b, expected 00000",
                     {tlp_valid_o, full_o, replaying_o, retrain_req_o, overflow_o});
        end
        assertions++;
        if (tlp_o !== '0) begin
            failures++;
            $display("[TB] FAIL reset_tlp: got seq %0d, expected all-zero", tlp_o[SEQ_MSB:SEQ_LSB]);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        flush();
        tlp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            write_tlp(k);
            assertions++;
            if (tlp_valid_o !== 1'b1 || tlp_o !== mk(k)) begin
                failures++;
                $display("[TB] FAIL stream_out%0d: got valid %b seq %0d, expected valid 1 seq %0d",
                         k, tlp_valid_o, tlp_o[SEQ_MSB:SEQ_LSB], k);
            end
        end
        step();
        assertions++;
        if (tlp_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_idle: got valid %b, expected 0", tlp_valid_o);
        end
        send_acknak(1'b0, 3);
        send_acknak(1'b1, 3);
        assertions++;
        if (replaying_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stream_nak_replaying: got %b, expected 1", replaying_o);
        end
        collect(6);
        assertions++;
        if (got_n !== 0) begin
            failures++;
            $display("[TB] FAIL stream_count0: got %0d replayed, expected 0", got_n);
        end
        assertions++;
        if (replaying_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_back_normal: got %b, expected 0", replaying_o);
        end
    endtask

    task automatic test_nak_replay();
        flush();
        tlp_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) write_tlp(k);
        step();
        send_acknak(1'b1, 1);
        assertions++;
        if (replaying_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL nak_replaying: got %b, expected 1", replaying_o);
        end
        collect(8);
        assertions++;
        if (got_n !== 3) begin
            failures++;
            $display("[TB] FAIL nak_count: got %0d, expected 3", got_n);
        end
        for (int i = 0; i < 3 && i < got_n; i++) begin
            assertions++;
            if (got_seq[i] !== 12'(i + 2) || got_ok[i] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL nak_seq%0d: got seq %0d data_ok %b, expected seq %0d data_ok 1",
                         i, got_seq[i], got_ok[i], i + 2);
            end
        end
        assertions++;
        if (replaying_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nak_back_normal: got %b, expected 0", replaying_o);
        end
    endtask

    task automatic test_timeout();
        int n;
        int rcnt;
        flush();
        tlp_ready_i = 1'b1;
        rcnt = 0;
        write_tlp(0);
        for (int t = 1; t <= 4; t++) begin
            n = 0;
            while (n < 1100) begin
                step();
                n++;
                if (retrain_req_o === 1'b1) rcnt++;
                if (tlp_valid_o === 1'b1) break;
            end
            if (t == 1) begin
                assertions++;
                if (n !== 1025) begin
                    failures++;
                    $display("[TB] FAIL timeout_latency: got %0d cycles, expected 1025", n);
                end
            end
            assertions++;
            if (tlp_valid_o !== 1'b1 || tlp_o !== mk(0)) begin
                failures++;
                $display("[TB] FAIL timeout_replay%0d: got valid %b seq %0d, expected valid 1 seq 0",
                         t, tlp_valid_o, tlp_o[SEQ_MSB:SEQ_LSB]);
            end
            assertions++;
            if (rcnt !== ((t == 4) ? 1 : 0)) begin
                failures++;
                $display("[TB] FAIL timeout_retrain%0d: got %0d pulses, expected %0d",
                         t, rcnt, (t == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_full_overflow();
        flush();
        tlp_ready_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            write_tlp(k);
            if (k == 14) begin
                assertions++;
                if (full_o !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL full_at15: got %b, expected 0", full_o);
                end
            end
        end
        assertions++;
        if (full_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL full_at16: got %b, expected 1", full_o);
        end
        write_tlp(16);
        assertions++;
        if (overflow_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_pulse: got %b, expected 1", overflow_o);
        end
        assertions++;
        if (tlp_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_nostore: got valid %b, expected 0", tlp_valid_o);
        end
        step();
        assertions++;
        if (overflow_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL overflow_one_cycle: got %b, expected 0", overflow_o);
        end
        send_acknak(1'b0, 0);
        assertions++;
        if (full_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL full_after_ack: got %b, expected 0", full_o);
        end
    endtask

    task automatic test_seq_wrap();
        flush();
        tlp_ready_i = 1'b1;
        write_tlp(4094);
        write_tlp(4095);
        write_tlp(0);
        write_tlp(1);
        step();
        send_acknak(1'b0, 0);
        send_acknak(1'b0, 4095);
        send_acknak(1'b1, 0);
        collect(8);
        assertions++;
        if (got_n !== 1) begin
            failures++;
            $display("[TB] FAIL wrap_count: got %0d left, expected 1", got_n);
        end
        assertions++;
        if (got_seq[0] !== 12'd1 || got_ok[0] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap_seq: got seq %0d data_ok %b, expected seq 1 data_ok 1",
                     got_seq[0], got_ok[0]);
        end
    endtask

    task automatic test_back_to_back();
        flush();
        tlp_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) write_tlp(k);
        step();
        tlp_ready_i = 1'b0;
        write_tlp(3);
        send_acknak(1'b1, 0);
        assertions++;
        if (replaying_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_replaying: got %b, expected 1", replaying_o);
        end
        for (int c = 0; c < 4; c++) begin
            assertions++;
            if (tlp_valid_o !== 1'b1 || tlp_o !== mk(3)) begin
                failures++;
                $display("[TB] FAIL hold_stable%0d: got valid %b seq %0d, expected valid 1 seq 3",
                         c, tlp_valid_o, tlp_o[SEQ_MSB:SEQ_LSB]);
            end
            step();
        end
        tlp_ready_i = 1'b1;
        collect(8);
        assertions++;
        if (got_n !== 4) begin
            failures++;
            $display("[TB] FAIL hold_count: got %0d, expected 4", got_n);
        end
        for (int i = 0; i < 4 && i < got_n; i++) begin
            assertions++;
            if (got_seq[i] !== ((i == 0) ? 12'd3 : 12'(i)) || got_ok[i] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL hold_seq%0d: got seq %0d data_ok %b, expected seq %0d data_ok 1",
                         i, got_seq[i], got_ok[i], (i == 0) ? 3 : i);
            end
        end
        tlp_ready_i = 1'b0;
        send_acknak(1'b1, 0);
        step();
        assertions++;
        if (replaying_o !== 1'b1 || tlp_valid_o !== 1'b1 || tlp_o !== mk(1)) begin
            failures++;
            $display("[TB] FAIL flush_pre: got replaying %b valid %b seq %0d, expected 1 1 seq 1",
                     replaying_o, tlp_valid_o, tlp_o[SEQ_MSB:SEQ_LSB]);
        end
        flush();
        assertions++;
        if ({tlp_valid_o, replaying_o, full_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL flush_outputs: got %b, expected 000",
                     {tlp_valid_o, replaying_o, full_o});
        end
        tlp_ready_i = 1'b1;
        repeat (3) step();
        assertions++;
        if (tlp_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_empty: got valid %b, expected 0", tlp_valid_o);
        end
        write_tlp(7);
        assertions++;
        if (tlp_valid_o !== 1'b1 || tlp_o !== mk(7)) begin
            failures++;
            $display("[TB] FAIL flush_resume: got valid %b seq %0d, expected valid 1 seq 7",
                     tlp_valid_o, tlp_o[SEQ_MSB:SEQ_LSB]);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_nak_replay();
        test_timeout();
        test_full_overflow();
        test_seq_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, expected end before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
